// File: rtl/float_triple_gatherer_pkg.sv
// Shared types for the float triple gatherer: operand triple, launch FSM states, padding constant.
package float_gather_pkg;

  localparam int FLEN = 64;

  typedef logic [0:2][FLEN-1:0] float_triple_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } launch_state_t;

  localparam logic [FLEN-1:0] FLOAT_POS_INF = 64'h7FF0_0000_0000_0000;

endpackage

// File: rtl/float_triple_gatherer_if.sv
// Upstream word stream plus sorter operand/launch bus; flush exists only with FLOAT_GATHER_FLUSH_EN.
interface float_triple_gatherer_if #(parameter int DEPTH = 2);
  import float_gather_pkg::*;

  logic                       up_valid;
  logic [FLEN-1:0]            up_data;
  logic                       up_ready;
`ifdef FLOAT_GATHER_FLUSH_EN
  logic                       flush;
`endif
  logic                       sort_valid_in;
  float_triple_t              sort_unsorted;
  logic                       sort_busy;
  logic                       sort_valid_out;
  logic                       sort_err;
  logic [$clog2(DEPTH+1)-1:0] triples_pending;
  logic                       err_seen;

  modport master (
`ifdef FLOAT_GATHER_FLUSH_EN
    input  flush,
`endif
    input  up_valid, up_data, sort_busy, sort_valid_out, sort_err,
    output up_ready, sort_valid_in, sort_unsorted, triples_pending, err_seen
  );

  modport slave (
`ifdef FLOAT_GATHER_FLUSH_EN
    output flush,
`endif
    output up_valid, up_data, sort_busy, sort_valid_out, sort_err,
    input  up_ready, sort_valid_in, sort_unsorted, triples_pending, err_seen
  );

endinterface

// File: rtl/float_triple_gatherer_fifo.sv
// DEPTH-entry triple FIFO with wrap-bit pointers; push into full and pop from empty are ignored.
module float_triple_fifo import float_gather_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  float_triple_t              push_dat,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output float_triple_t              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  float_triple_t mem_q [DEPTH];
  float_triple_t mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = CW'(wr_ptr_q - rd_ptr_q);
  // Zero head when empty so the sorter never sees a stale retired triple.
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/float_triple_gatherer.sv
// Packs upstream floats into triples, buffers them, and launches one at a time to the sorter (first launch 2 cycles after the third word).
// up_ready falls only when a third word has nowhere to go; FLOAT_GATHER_FLUSH_EN adds a +inf-padded flush.
module float_triple_gatherer import float_gather_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  float_triple_gatherer_if.master bus
);

  logic [1:0]      idx_q, idx_d;
  logic [FLEN-1:0] stage0_q, stage0_d, stage1_q, stage1_d;
  launch_state_t   state_q, state_d;
  logic            err_seen_q, err_seen_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  float_triple_t   fifo_push_dat, fifo_head;
  logic            accept;
  logic            flush_req;

`ifdef FLOAT_GATHER_FLUSH_EN
  assign flush_req = bus.flush;
`else
  assign flush_req = 1'b0;
`endif

  // Depends on registered state only; a flush cycle never takes a word.
  assign bus.up_ready = !((idx_q == 2'd2) && fifo_full) && !flush_req;
  assign accept       = bus.up_valid && bus.up_ready;

  always_comb begin
    idx_d         = idx_q;
    stage0_d      = stage0_q;
    stage1_d      = stage1_q;
    fifo_push     = 1'b0;
    fifo_push_dat = '0;
    if (accept) begin
      case (idx_q)
        2'd0: begin
          stage0_d = bus.up_data;
          idx_d    = 2'd1;
        end
        2'd1: begin
          stage1_d = bus.up_data;
          idx_d    = 2'd2;
        end
        default: begin
          fifo_push     = 1'b1;
          fifo_push_dat = {stage0_q, stage1_q, bus.up_data};
          idx_d         = 2'd0;
        end
      endcase
    end else if (flush_req && (idx_q != 2'd0) && !fifo_full) begin
      fifo_push     = 1'b1;
      fifo_push_dat = (idx_q == 2'd1) ? {stage0_q, FLOAT_POS_INF, FLOAT_POS_INF}
                                      : {stage0_q, stage1_q, FLOAT_POS_INF};
      idx_d         = 2'd0;
    end
  end

  always_comb begin
    state_d           = state_q;
    fifo_pop          = 1'b0;
    bus.sort_valid_in = 1'b0;
    err_seen_d        = err_seen_q | bus.sort_err;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.sort_busy) state_d = ISSUE;
      end
      ISSUE: begin
        bus.sort_valid_in = 1'b1;
        if (bus.sort_err) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.sort_valid_out || bus.sort_err) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= 2'd0;
      stage0_q   <= '0;
      stage1_q   <= '0;
      state_q    <= IDLE;
      err_seen_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      stage0_q   <= stage0_d;
      stage1_q   <= stage1_d;
      state_q    <= state_d;
      err_seen_q <= err_seen_d;
    end
  end

  float_triple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (bus.triples_pending),
    .head     (fifo_head)
  );

  assign bus.sort_unsorted = fifo_head;
  assign bus.err_seen      = err_seen_q;

endmodule

// File: tb/tb_float_triple_gatherer.sv
// Bench for float_triple_gatherer: 3-cycle model sorter, launch scoreboard, table vectors and corner-case sequences.
module tb_float_triple_gatherer;
  import float_gather_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [63:0] F1   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F2   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F3   = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F4   = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F5   = 64'h4014_0000_0000_0000;
  localparam logic [63:0] SNAN = 64'h7FF0_0000_0000_0001;

  typedef struct packed {
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w2;
    logic        err_exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_triple_gatherer_if #(.DEPTH(DEPTH)) bus ();
  float_triple_gatherer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model sorter: result valid three cycles after a launch, immediate error on a signalling NaN.
  logic       busy_force;
  logic [2:0] sh = '0;
  logic       has_snan;
  assign has_snan = (bus.sort_unsorted[0] == SNAN) || (bus.sort_unsorted[1] == SNAN) ||
                    (bus.sort_unsorted[2] == SNAN);
  assign bus.sort_busy      = busy_force;
  assign bus.sort_err       = bus.sort_valid_in && has_snan;
  assign bus.sort_valid_out = sh[2];

  initial forever begin
    @(posedge clk);
    sh  <= {sh[1:0], bus.sort_valid_in && !bus.sort_err};
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  float_triple_t exp_q[$];
  float_triple_t held;
  bit            inflight = 0;
  bit            prev_vin = 0;
  int            launch_t[$];
  logic [63:0]   stg[3];
  int            wcnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      inflight = 0;
      prev_vin = 0;
    end else begin
      if (bus.sort_valid_in) begin
        chk("no_back_to_back", 192'(prev_vin), 192'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: got %0h with nothing expected", bus.sort_unsorted);
        end else begin
          held = exp_q.pop_front();
          chk("launch_operands", bus.sort_unsorted, held);
        end
        launch_t.push_back(cyc);
        inflight = !bus.sort_err;
      end else if (inflight) begin
        chk("operands_stable", bus.sort_unsorted, held);
        if (bus.sort_valid_out) inflight = 0;
      end
      prev_vin = bus.sort_valid_in;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    int t = 0;
    bus.up_valid = 1'b1;
    bus.up_data  = w;
    while (!bus.up_ready && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.up_ready) begin
      checks++;
      errors++;
      $display("FAIL up_ready_timeout: got up_ready=0 expected 1 within 60 cycles");
      bus.up_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    stg[wcnt] = w;
    wcnt++;
    if (wcnt == 3) begin
      exp_q.push_back({stg[0], stg[1], stg[2]});
      wcnt = 0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((bus.triples_pending != 0 || inflight) && t < 100) begin
      step();
      t++;
    end
    chk("drain_done", 192'(bus.triples_pending == 0 && !inflight), 192'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_up_ready"}, 192'(bus.up_ready), 192'(1));
    chk({tag, "_sort_valid_in"}, 192'(bus.sort_valid_in), 192'(0));
    chk({tag, "_sort_unsorted"}, bus.sort_unsorted, 192'(0));
    chk({tag, "_pending"}, 192'(bus.triples_pending), 192'(0));
    chk({tag, "_err_seen"}, 192'(bus.err_seen), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  vec_t tbl[5];

  initial begin
    tbl[0] = '{F1, F2, F3, 1'b0};
    tbl[1] = '{64'hC000_0000_0000_0000, F5, 64'h0, 1'b0};
    tbl[2] = '{F4, SNAN, F1, 1'b1};
    tbl[3] = '{F2, F2, F1, 1'b1};
    tbl[4] = '{64'hFFF0_0000_0000_0000, F3, 64'h7FF8_0000_0000_0000, 1'b1};

    bus.up_valid = 1'b0;
    bus.up_data  = '0;
`ifdef FLOAT_GATHER_FLUSH_EN
    bus.flush    = 1'b0;
`endif
    busy_force = 1'b0;
    rst = 1'b1;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single triple: latency from third accepted word.
    send_word(F3);
    send_word(F1);
    send_word(F2);
    step();
    chk("t1_pending", 192'(bus.triples_pending), 192'(1));
    chk("t1_vin_low", 192'(bus.sort_valid_in), 192'(0));
    step();
    chk("t2_vin_high", 192'(bus.sort_valid_in), 192'(1));
    chk("t2_operands", bus.sort_unsorted, {F3, F1, F2});
    repeat (3) step();
    chk("t5_pending", 192'(bus.triples_pending), 192'(1));
    step();
    chk("t6_pending", 192'(bus.triples_pending), 192'(0));
    chk("t6_unsorted_zero", bus.sort_unsorted, 192'(0));

    // Table vectors, including a signalling-NaN error and sticky err_seen.
    for (int i = 0; i < 5; i++) begin
      send_word(tbl[i].w0);
      send_word(tbl[i].w1);
      send_word(tbl[i].w2);
      wait_drain();
      chk("tbl_err_seen", 192'(bus.err_seen), 192'(tbl[i].err_exp));
      chk("tbl_pending", 192'(bus.triples_pending), 192'(0));
    end

    // Backpressure with the sorter stalled.
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) send_word(64'h4020_0000_0000_0000 + 64'(i));
    step();
    chk("bp_up_ready_low", 192'(bus.up_ready), 192'(0));
    chk("bp_pending_full", 192'(bus.triples_pending), 192'(2));
    chk("bp_no_launch", 192'(bus.sort_valid_in), 192'(0));
    launch_t.delete();
    fork
      send_word(64'h4020_0000_0000_0008);
      begin
        step();
        step();
        busy_force = 1'b0;
      end
    join
    wait_drain();
    chk("bp_launch_count", 192'(launch_t.size()), 192'(3));
    if (launch_t.size() == 3) begin
      chk("bp_gap_0", 192'(launch_t[1] - launch_t[0]), 192'(5));
      chk("bp_gap_1", 192'(launch_t[2] - launch_t[1]), 192'(5));
    end

    // Third word of B lands on the edge that pops A.
    send_word(F1);
    send_word(F1);
    send_word(F1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    send_word(F4);
    send_word(F5);
    send_word(F2);
    step();
    chk("pp_pending", 192'(bus.triples_pending), 192'(1));
    chk("pp_head_is_b", bus.sort_unsorted, {F4, F5, F2});
    wait_drain();

    // Asynchronous reset while the launch is waiting on the sorter.
    send_word(F2);
    send_word(F3);
    send_word(F4);
    send_word(F5);
    step();
    step();
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    exp_q.delete();
    wcnt = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    repeat (3) step();
    chk("stale_pending", 192'(bus.triples_pending), 192'(0));
    chk("stale_ready", 192'(bus.up_ready), 192'(1));
    send_word(F5);
    send_word(F4);
    send_word(F3);
    wait_drain();

`ifdef FLOAT_GATHER_FLUSH_EN
    send_word(F5);
    send_word(F4);
    step();
    bus.flush = 1'b1;
    #1;
    chk("flush_up_ready_low", 192'(bus.up_ready), 192'(0));
    exp_q.push_back({F5, F4, FLOAT_POS_INF});
    wcnt = 0;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_pending", 192'(bus.triples_pending), 192'(1));
    wait_drain();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_idle_noop", 192'(bus.triples_pending), 192'(0));
`endif

    repeat (4) step();
    chk("final_queue_empty", 192'(exp_q.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
